// File: rtl/fft8_pkg.sv
// Shared constants, sample type and slicing helper for the 8-point FFT frame controller.
package fft8_pkg;

    localparam int N_PTS = 8;
    localparam int IDX_W = 3;
    localparam int W_DEF = 24;

    typedef struct packed {
        logic signed [W_DEF-1:0] re;
        logic signed [W_DEF-1:0] im;
    } cplx_t;

    // Low bit of sample/bin k inside a frame packed as k*w +: w.
    function automatic int slot_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/fft8_out_fbuf.sv
// Frame-granular circular output buffer: captures a whole FFT result in one cycle
// and replays it one bin per handshake, in bin order.
module fft8_out_fbuf
    import fft8_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int OUT_FRAMES = 2,
    parameter int CW         = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap,
    input  logic [N_PTS*W-1:0] cap_real,
    input  logic [N_PTS*W-1:0] cap_imag,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W-1:0]       m_real,
    output logic [W-1:0]       m_imag,
    output logic [IDX_W-1:0]   m_index,
    output logic               m_last,
    output logic               frame_drained,
    output logic [CW-1:0]      occupied
);

    localparam int PW = (OUT_FRAMES > 1) ? $clog2(OUT_FRAMES) : 1;

    logic [W-1:0]     mem_re [OUT_FRAMES][N_PTS];
    logic [W-1:0]     mem_im [OUT_FRAMES][N_PTS];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [IDX_W-1:0] idx;
    logic             pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(OUT_FRAMES - 1)) ? '0 : p + 1'b1;
    endfunction

    assign m_valid       = (occupied != '0);
    assign pop           = m_valid && m_ready;
    assign m_last        = m_valid && (idx == IDX_W'(N_PTS - 1));
    assign frame_drained = pop && m_last;
    assign m_index       = idx;
    // The head slot is never the capture target, so these stay stable under stall.
    assign m_real        = mem_re[rd_ptr][idx];
    assign m_imag        = mem_im[rd_ptr][idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int f = 0; f < OUT_FRAMES; f++) begin
                for (int k = 0; k < N_PTS; k++) begin
                    mem_re[f][k] <= '0;
                    mem_im[f][k] <= '0;
                end
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            idx      <= '0;
            occupied <= '0;
        end else begin
            if (cap) begin
                for (int k = 0; k < N_PTS; k++) begin
                    mem_re[wr_ptr][k] <= cap_real[slot_lo(k, W) +: W];
                    mem_im[wr_ptr][k] <= cap_imag[slot_lo(k, W) +: W];
                end
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                if (m_last) begin
                    idx    <= '0;
                    rd_ptr <= ptr_next(rd_ptr);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            case ({cap, frame_drained})
                2'b10:   occupied <= occupied + 1'b1;
                2'b01:   occupied <= occupied - 1'b1;
                default: occupied <= occupied;
            endcase
        end
    end

endmodule

// File: rtl/fft8_frame_ctrl.sv
// Frame scheduler for the 8-point parallel FFT: serial-to-frame collection, credit-gated
// launch, fixed-latency result tracking and serial replay of the bins.
module fft8_frame_ctrl
    import fft8_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int FFT_LAT    = 4,
    parameter int OUT_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [W-1:0]       s_real,
    input  logic [W-1:0]       s_imag,
    output logic               fft_en,
    output logic [N_PTS*W-1:0] fft_x_real,
    output logic [N_PTS*W-1:0] fft_x_imag,
    input  logic               fft_valid,
    input  logic [N_PTS*W-1:0] fft_y_real,
    input  logic [N_PTS*W-1:0] fft_y_imag,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [W-1:0]       m_real,
    output logic [W-1:0]       m_imag,
    output logic [IDX_W-1:0]   m_index,
    output logic               m_last,
    output logic [15:0]        frames_done,
    output logic               err_timeout,
    output logic               err_unexpected
);

    localparam int CW = $clog2(OUT_FRAMES + 1) + 1;
    localparam int FW = $clog2(FFT_LAT + 1);

    logic [IDX_W-1:0]   wr_cnt;
    logic               full;
    logic               accept;
    logic [FFT_LAT-1:0] exp_sr;
    logic               exp_tail;
    logic [FW-1:0]      flush_cnt;
    logic               flushing;
    logic               capture;
    logic [CW-1:0]      inflight;
    logic [CW-1:0]      occupied;
    logic               frame_drained;

    // Both streams: a beat transfers on a cycle where valid && ready are high at the
    // rising edge; a source holds data stable while valid is high and ready is low.
    assign s_ready  = !full && !rst;
    assign accept   = s_valid && s_ready;
    // A frame may launch only when a buffer slot is guaranteed for its result.
    assign fft_en   = !rst && full && ((inflight + occupied) < CW'(OUT_FRAMES));
    assign exp_tail = exp_sr[FFT_LAT-1];
    assign flushing = (flush_cnt != '0);
    assign capture  = fft_valid && exp_tail;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            full       <= 1'b0;
            fft_x_real <= '0;
            fft_x_imag <= '0;
        end else begin
            if (accept) begin
                fft_x_real[slot_lo(int'(wr_cnt), W) +: W] <= s_real;
                fft_x_imag[slot_lo(int'(wr_cnt), W) +: W] <= s_imag;
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == IDX_W'(N_PTS - 1))
                    full <= 1'b1;
            end
            if (fft_en)
                full <= 1'b0;
        end
    end

    // Results still in the FFT pipe at reset drain out during the flush window.
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_sr         <= '0;
            flush_cnt      <= FW'(FFT_LAT);
            inflight       <= '0;
            err_timeout    <= 1'b0;
            err_unexpected <= 1'b0;
            frames_done    <= '0;
        end else begin
            exp_sr <= (exp_sr << 1) | FFT_LAT'(fft_en);
            if (flushing)
                flush_cnt <= flush_cnt - 1'b1;
            case ({fft_en, exp_tail})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
            if (exp_tail && !fft_valid)
                err_timeout <= 1'b1;
            if (fft_valid && !exp_tail && !flushing)
                err_unexpected <= 1'b1;
            if (frame_drained)
                frames_done <= frames_done + 1'b1;
        end
    end

    fft8_out_fbuf #(
        .W          (W),
        .OUT_FRAMES (OUT_FRAMES),
        .CW         (CW)
    ) u_fbuf (
        .clk           (clk),
        .rst           (rst),
        .cap           (capture),
        .cap_real      (fft_y_real),
        .cap_imag      (fft_y_imag),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_real        (m_real),
        .m_imag        (m_imag),
        .m_index       (m_index),
        .m_last        (m_last),
        .frame_drained (frame_drained),
        .occupied      (occupied)
    );

endmodule

// File: tb/tb_fft8_frame_ctrl.sv
// Directed bench for fft8_frame_ctrl with a behavioural fixed-latency FFT and a bin scoreboard.
module tb_fft8_frame_ctrl;
    import fft8_pkg::*;

    localparam int W = 24, FFT_LAT = 4, OUT_FRAMES = 2, EW = 2 * W + 3;

    logic             clk = 1'b0, rst = 1'b1;
    logic             s_valid = 1'b0, s_ready;
    logic [W-1:0]     s_real = '0, s_imag = '0;
    logic             fft_en, fft_valid;
    logic [8*W-1:0]   fft_x_real, fft_x_imag, fft_y_real, fft_y_imag;
    logic             m_valid, m_ready = 1'b0, m_last;
    logic [W-1:0]     m_real, m_imag;
    logic [2:0]       m_index;
    logic [15:0]      frames_done;
    logic             err_timeout, err_unexpected;

    int checks = 0, errors = 0;
    logic [EW-1:0] exp_q[$];

    int fa_r[8] = '{10, 20, 30, 40, 10, 20, 30, 40};
    int fa_i[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int fb_r[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int fb_i[8] = '{-3, -2, -1, 0, 1, 2, 3, 4};
    int fc_r[8] = '{8388607, -8388608, 100, -100, 0, 77, -5, 12345};
    int fc_i[8] = '{-1, 1, -8388608, 8388607, 9, -9, 0, 31};

    always #5 clk = ~clk;

    fft8_frame_ctrl #(.W(W), .FFT_LAT(FFT_LAT), .OUT_FRAMES(OUT_FRAMES)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_imag(s_imag), .fft_en(fft_en),
        .fft_x_real(fft_x_real), .fft_x_imag(fft_x_imag), .fft_valid(fft_valid),
        .fft_y_real(fft_y_real), .fft_y_imag(fft_y_imag), .m_valid(m_valid),
        .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag), .m_index(m_index),
        .m_last(m_last), .frames_done(frames_done), .err_timeout(err_timeout),
        .err_unexpected(err_unexpected)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi($floor(r + 0.5)) : -$rtoi($floor(-r + 0.5));
    endfunction

    function automatic void dft8(input int xr[8], input int xi[8], output int yr[8], output int yi[8]);
        for (int k = 0; k < 8; k++) begin
            real sr = 0.0, si = 0.0;
            for (int n = 0; n < 8; n++) begin
                real a = -2.0 * 3.14159265358979323846 * k * n / 8.0;
                sr = sr + xr[n] * $cos(a) - xi[n] * $sin(a);
                si = si + xr[n] * $sin(a) + xi[n] * $cos(a);
            end
            yr[k] = rnd(sr);
            yi[k] = rnd(si);
        end
    endfunction

    function automatic logic [EW-1:0] beat(input int idx, input int re, input int im);
        return {3'(idx), W'(re), W'(im)};
    endfunction

    task automatic push_dft(input int xr[8], input int xi[8]);
        int yr[8], yi[8];
        dft8(xr, xi, yr, yi);
        for (int k = 0; k < 8; k++) exp_q.push_back(beat(k, yr[k], yi[k]));
    endtask

    // ---------------- behavioural FFT: result FFT_LAT cycles after fft_en ----------------
    bit   pv[FFT_LAT+1];
    int   pr[FFT_LAT+1][8];
    int   pim[FFT_LAT+1][8];
    int   launches = 0;
    int   drop_at = -1;
    logic inj_valid = 1'b0;

    always @(negedge clk) begin
        int xr[8], xi[8], yr[8], yi[8];
        for (int s = FFT_LAT; s > 0; s--) begin
            pv[s] = pv[s-1];
            pr[s] = pr[s-1];
            pim[s] = pim[s-1];
        end
        pv[0] = 1'b0;
        if (fft_en) begin
            for (int k = 0; k < 8; k++) begin
                xr[k] = int'($signed(fft_x_real[k*W +: W]));
                xi[k] = int'($signed(fft_x_imag[k*W +: W]));
            end
            dft8(xr, xi, yr, yi);
            pr[0] = yr;
            pim[0] = yi;
            pv[0] = (launches != drop_at);
            launches++;
        end
        fft_valid = pv[FFT_LAT] | inj_valid;
        for (int k = 0; k < 8; k++) begin
            fft_y_real[k*W +: W] = W'(pr[FFT_LAT][k]);
            fft_y_imag[k*W +: W] = W'(pim[FFT_LAT][k]);
        end
    end

    // ---------------- scoreboard and stall-stability monitor ----------------
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_beat;

    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", {m_index, m_real, m_imag}, prev_beat);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_index, m_real, m_imag}, e);
                    check("m_last", m_last, (e[EW-1 -: 3] == 3'd7));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_index, m_real, m_imag};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        exp_q.delete();
        tick();
        tick();
        @(negedge clk);
        check("rst_s_ready", s_ready, 0);
        check("rst_fft_en", fft_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_index", m_index, 0);
        check("rst_frames_done", frames_done, 0);
        check("rst_err_timeout", err_timeout, 0);
        check("rst_err_unexpected", err_unexpected, 0);
        check("rst_fft_x", |{fft_x_real, fft_x_imag}, 0);
        check("rst_m_data", |{m_real, m_imag}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        tick();
    endtask

    task automatic send_sample(input int re, input int im);
        int n = 0;
        s_valid = 1'b1;
        s_real = W'(re);
        s_imag = W'(im);
        @(negedge clk);
        while (!s_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check("s_ready_wait", s_ready, 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int xr[8], input int xi[8], input bit push);
        if (push) push_dft(xr, xi);
        for (int k = 0; k < 8; k++) send_sample(xr[k], xi[k]);
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        @(negedge clk);
        while (frames_done != 16'(target) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("frames_done", frames_done, target);
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        int base, n, k;
        bit stop;

        // Single frame with hand-computed bins.
        do_reset();
        m_ready = 1'b1;
        base = launches;
        exp_q.push_back(beat(0, 200, 0));
        exp_q.push_back(beat(1, 0, 0));
        exp_q.push_back(beat(2, -40, 40));
        exp_q.push_back(beat(3, 0, 0));
        exp_q.push_back(beat(4, -40, 0));
        exp_q.push_back(beat(5, 0, 0));
        exp_q.push_back(beat(6, -40, -40));
        exp_q.push_back(beat(7, 0, 0));
        send_frame(fa_r, fa_i, 1'b0);
        @(negedge clk);
        check("t1_fft_en", fft_en, 1);
        for (int i = 0; i < 8; i++) begin
            check("t1_x_real", fft_x_real[i*W +: W], W'(fa_r[i]));
            check("t1_x_imag", fft_x_imag[i*W +: W], W'(fa_i[i]));
        end
        wait_frames(1);
        check("t1_launches", launches - base, 1);
        check("t1_q_empty", exp_q.size(), 0);
        check("t1_errs", {err_timeout, err_unexpected}, 0);

        // Backpressure and credit: third launch waits for frame 0 to drain.
        do_reset();
        base = launches;
        fork
            begin
                send_frame(fa_r, fa_i, 1'b1);
                send_frame(fb_r, fb_i, 1'b1);
                send_frame(fc_r, fc_i, 1'b1);
            end
            begin
                n = 0;
                @(negedge clk);
                while (launches - base < 2 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                repeat (30) @(negedge clk);
                check("t2_launches", launches - base, 2);
                check("t2_s_ready", s_ready, 0);
                check("t2_fft_en", fft_en, 0);
                check("t2_m_valid", m_valid, 1);
                tick();
                m_ready = 1'b1;
                n = 0;
                @(negedge clk);
                while (!fft_en && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                check("t2_third_launch", fft_en, 1);
                check("t2_drained_before_launch", frames_done, 1);
            end
        join
        wait_frames(3);
        check("t2_q_empty", exp_q.size(), 0);

        // Output stalls every other cycle.
        do_reset();
        stop = 1'b0;
        fork
            begin
                send_frame(fb_r, fb_i, 1'b1);
                send_frame(fc_r, fc_i, 1'b1);
                send_frame(fa_r, fa_i, 1'b1);
                wait_frames(3);
                stop = 1'b1;
            end
            begin
                n = 0;
                while (!stop && n < 2000) begin
                    m_ready = ~m_ready;
                    tick();
                    n++;
                end
                m_ready = 1'b1;
            end
        join
        check("t3_q_empty", exp_q.size(), 0);

        // Missing result for frame 1.
        do_reset();
        m_ready = 1'b1;
        drop_at = launches + 1;
        fork
            begin
                send_frame(fa_r, fa_i, 1'b1);
                send_frame(fb_r, fb_i, 1'b0);
                send_frame(fc_r, fc_i, 1'b1);
            end
            begin
                k = 0;
                for (n = 0; n < 300 && k < 2; n++) begin
                    @(negedge clk);
                    if (fft_en) k++;
                end
                check("t4_second_launch", k, 2);
                repeat (FFT_LAT - 1) @(negedge clk);
                check("t4_timeout_early", err_timeout, 0);
                repeat (2) @(negedge clk);
                check("t4_timeout_set", err_timeout, 1);
            end
        join
        wait_frames(2);
        drop_at = -1;
        check("t4_timeout_sticky", err_timeout, 1);
        check("t4_unexpected", err_unexpected, 0);
        check("t4_q_empty", exp_q.size(), 0);

        // Spurious results: ignored inside the flush window, flagged afterwards.
        do_reset();
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("t5_flush_no_flag", err_unexpected, 0);
        repeat (12) tick();
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        @(negedge clk);
        check("t5_unexpected", err_unexpected, 1);
        check("t5_m_valid", m_valid, 0);
        repeat (3) tick();
        @(negedge clk);
        check("t5_m_valid_later", m_valid, 0);
        check("t5_no_timeout", err_timeout, 0);
        tick();

        // Reset mid-frame with one frame buffered.
        do_reset();
        m_ready = 1'b1;
        send_frame(fc_r, fc_i, 1'b1);
        wait_frames(1);
        m_ready = 1'b0;
        send_frame(fb_r, fb_i, 1'b0);
        n = 0;
        @(negedge clk);
        while (!m_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_buffered", m_valid, 1);
        tick();
        for (int i = 0; i < 5; i++) send_sample(fa_r[i] + 7, -i);
        do_reset();
        m_ready = 1'b1;
        send_frame(fb_r, fb_i, 1'b1);
        wait_frames(1);
        check("t6_q_empty", exp_q.size(), 0);
        check("t6_errs", {err_timeout, err_unexpected}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
